// File: rtl/xadc_drp_multichannel_scanner.sv
// xadc_drp_multichannel_scanner
// After each XADC end-of-sequence pulse, reads NUM_CHANNELS DRP result
// registers in order and emits them as one AXI-Stream packet (tdest =
// channel index, tlast on the final channel). Counts EOS pulses that arrive
// while a sweep is still running.
// Optional feature macro: XADC_SCANNER_TIMEOUT_EN adds a DRP response
// watchdog that aborts the sweep and counts timeouts. Without it the scanner
// waits for xadc_drdy indefinitely and timeout_count is tied to zero.
module xadc_drp_multichannel_scanner #(
  parameter int          NUM_CHANNELS   = 2,
  parameter int          SAMPLE_WIDTH   = 12,
  parameter logic [55:0] CHANNEL_ADDRS  = 56'h0000_0000_0D93,
  parameter int          TIMEOUT_CYCLES = 64,
  localparam int         CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    xadc_dclk,
  input  logic                    xadc_reset_n,
  output logic [6:0]              xadc_daddr,
  output logic                    xadc_den,
  output logic                    xadc_dwe,
  input  logic                    xadc_drdy,
  input  logic [15:0]             xadc_do,
  input  logic                    xadc_eos,
  output logic [SAMPLE_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [CH_W-1:0]         m_axis_tdest,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic [15:0]             overrun_count,
  output logic [15:0]             timeout_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DRDY = 2'd2,
    PRESENT   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         idx_q, idx_d;
  logic [SAMPLE_WIDTH-1:0] tdata_q, tdata_d;
  logic [CH_W-1:0]         tdest_q, tdest_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic [15:0]             overrun_q, overrun_d;

  logic                    idx_is_last;
  logic                    handshake;
  logic                    last_handshake;

  // Per-channel DRP address table unpacked from the packed parameter;
  // bits above 7*NUM_CHANNELS are never referenced.
  logic [6:0] addr_tbl [NUM_CHANNELS];

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_addr
      assign addr_tbl[gi] = CHANNEL_ADDRS[7*gi +: 7];
    end
  endgenerate

  assign idx_is_last    = (idx_q == CH_W'(NUM_CHANNELS - 1));
  assign handshake      = tvalid_q & m_axis_tready;
  assign last_handshake = (state_q == PRESENT) & handshake & tlast_q;

`ifdef XADC_SCANNER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            wd_expire;

  // Watchdog fires on the TIMEOUT_CYCLES-th WAIT_DRDY cycle without drdy.
  assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state, datapath capture and counter update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tdata_d   = tdata_q;
    tdest_d   = tdest_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;
`ifdef XADC_SCANNER_TIMEOUT_EN
    wd_d      = wd_q;
    tmo_d     = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (xadc_eos) begin
          idx_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
`ifdef XADC_SCANNER_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = WAIT_DRDY;
      end

      WAIT_DRDY: begin
        if (xadc_drdy) begin
          // MSB-aligned truncation of the 16-bit DRP word.
          tdata_d  = xadc_do[15 -: SAMPLE_WIDTH];
          tdest_d  = idx_q;
          tlast_d  = idx_is_last;
          tvalid_d = 1'b1;
          state_d  = PRESENT;
        end
`ifdef XADC_SCANNER_TIMEOUT_EN
        else if (wd_expire) begin
          // Abandon the rest of the sweep; beats already sent stay sent.
          state_d = IDLE;
          if (tmo_q != 16'hFFFF) begin
            tmo_d = tmo_q + 16'd1;
          end
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end

      PRESENT: begin
        if (handshake) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            // An EOS landing on the final handshake starts the next sweep
            // straight away instead of being dropped.
            if (xadc_eos) begin
              idx_d   = '0;
              state_d = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + CH_W'(1);
            state_d = ISSUE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // EOS while a sweep is in flight is dropped and counted.
    if (xadc_eos && (state_q != IDLE) && !last_handshake && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tdata_q   <= '0;
      tdest_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tdata_q   <= tdata_d;
      tdest_q   <= tdest_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef XADC_SCANNER_TIMEOUT_EN
  // Watchdog counter and timeout statistic.
  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n) begin
      wd_q  <= '0;
      tmo_q <= '0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_count = tmo_q;
`else
  assign timeout_count = 16'h0000;
`endif

  // DRP strobe is a decode of ISSUE, so it is one cycle wide and drops
  // immediately with reset.
  assign xadc_den   = (state_q == ISSUE);
  assign xadc_daddr = (state_q == ISSUE) ? addr_tbl[idx_q] : 7'h00;
  assign xadc_dwe   = 1'b0;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdest  = tdest_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign overrun_count = overrun_q;

  // Low DRP bits below the sample and the watchdog limit (when the watchdog
  // is compiled out) are intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{xadc_do, (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_xadc_drp_multichannel_scanner.sv
// Testbench for xadc_drp_multichannel_scanner (default parameters,
// TIMEOUT_CYCLES = 8). Timeout scenario runs when XADC_SCANNER_TIMEOUT_EN is
// defined. Inputs change 1 time unit after the rising edge; outputs are
// observed on the falling edge.
module tb_xadc_drp_multichannel_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  xadc_daddr;
  logic        xadc_den;
  logic        xadc_dwe;
  logic        xadc_drdy = 1'b0;
  logic [15:0] xadc_do = 16'h0000;
  logic        xadc_eos = 1'b0;
  logic [11:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [0:0]  m_axis_tdest;
  logic        m_axis_tlast;
  logic        busy;
  logic [15:0] overrun_count;
  logic [15:0] timeout_count;

  always #5 clk = ~clk;

  xadc_drp_multichannel_scanner #(.TIMEOUT_CYCLES(8)) dut (
    .xadc_dclk     (clk),
    .xadc_reset_n  (rst_n),
    .xadc_daddr    (xadc_daddr),
    .xadc_den      (xadc_den),
    .xadc_dwe      (xadc_dwe),
    .xadc_drdy     (xadc_drdy),
    .xadc_do       (xadc_do),
    .xadc_eos      (xadc_eos),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .overrun_count (overrun_count),
    .timeout_count (timeout_count)
  );

  typedef struct packed {
    logic [11:0] d;
    logic [0:0]  dest;
    logic        last;
  } beat_t;

  typedef struct {
    int          lat;
    int          stall;
    int          extra;
    logic [15:0] d13;
    logic [15:0] d1b;
    logic [11:0] e0;
    logic [11:0] e1;
    logic [15:0] ovr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // XADC model state
  int          lat = 2;
  logic [15:0] d13 = 16'hABC0;
  logic [15:0] d1b = 16'h1230;
  bit          withhold_1b = 1'b0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [6:0]  paddr = 7'h00;
  int          den_cnt = 0;
  bit          den_prev = 1'b0;
  int          den_viol = 0;
  logic [6:0]  addr_q[$];
  beat_t       beats[$];

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // XADC DRP responder plus den and beat monitors, all on the falling edge.
  always @(negedge clk) begin
    xadc_drdy = 1'b0;
    if (xadc_den) begin
      den_cnt++;
      addr_q.push_back(xadc_daddr);
      if (den_prev || pend) den_viol++;
      if (!(withhold_1b && xadc_daddr == 7'h1B)) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = xadc_daddr;
      end
    end else if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend      = 1'b0;
        xadc_drdy = 1'b1;
        xadc_do   = (paddr == 7'h13) ? d13 : (paddr == 7'h1B) ? d1b : 16'hDEAD;
      end
    end
    den_prev = xadc_den;
    if (rst_n && m_axis_tvalid && m_axis_tready)
      beats.push_back({m_axis_tdata, m_axis_tdest, m_axis_tlast});
  end

  task automatic run_sweep(input vec_t e, input string tag);
    int    stall_left;
    bit    stable_ok;
    bit    holding;
    beat_t held;
    int    den_at_stall_end;
    bit    done;
    lat = e.lat;
    d13 = e.d13;
    d1b = e.d1b;
    beats.delete();
    addr_q.delete();
    den_cnt = 0;
    stall_left = e.stall;
    stable_ok = 1'b1;
    holding = 1'b0;
    held = '0;
    den_at_stall_end = -1;
    done = 1'b0;
    m_axis_tready = 1'b1;
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
    for (int c = 1; c <= 300 && !done; c++) begin
      xadc_eos = (c <= 2 * e.extra) && (c % 2 == 0);
      if (m_axis_tvalid && beats.size() == 0 && stall_left > 0) begin
        if (!holding) begin
          held = {m_axis_tdata, m_axis_tdest, m_axis_tlast};
          holding = 1'b1;
        end else if ({m_axis_tdata, m_axis_tdest, m_axis_tlast} !== held) begin
          stable_ok = 1'b0;
        end
        m_axis_tready = 1'b0;
        stall_left--;
      end else begin
        if (holding && den_at_stall_end < 0) den_at_stall_end = den_cnt;
        m_axis_tready = 1'b1;
      end
      tick();
      if (!busy && beats.size() >= 2) done = 1'b1;
    end
    xadc_eos = 1'b0;
    m_axis_tready = 1'b1;
    check({tag, " done"}, done, 1);
    check({tag, " nbeats"}, beats.size(), 2);
    check({tag, " beat0"}, beats[0], {e.e0, 1'b0, 1'b0});
    check({tag, " beat1"}, beats[1], {e.e1, 1'b1, 1'b1});
    check({tag, " den_count"}, den_cnt, 2);
    check({tag, " daddr0"}, addr_q[0], 7'h13);
    check({tag, " daddr1"}, addr_q[1], 7'h1B);
    check({tag, " overrun"}, overrun_count, e.ovr);
    if (e.stall > 0) begin
      check({tag, " stall_stable"}, stable_ok, 1);
      check({tag, " stall_no_den"}, den_at_stall_end, 1);
    end
    $display("sweep %s: beats=%0d d0=%h d1=%h overrun=%0d", tag, beats.size(),
             beats[0].d, beats[1].d, overrun_count);
  endtask

  initial begin
    bit hit;
    bit done;
    //            lat stall extra d13      d1b      e0      e1      ovr
    vecs[0] = '{2, 0,  0, 16'hABC0, 16'h1230, 12'hABC, 12'h123, 16'd0};
    vecs[1] = '{1, 10, 0, 16'h5A5F, 16'hFFFF, 12'h5A5, 12'hFFF, 16'd0};
    vecs[2] = '{3, 0,  3, 16'h0000, 16'h8001, 12'h000, 12'h800, 16'd3};
    vecs[3] = '{2, 2,  1, 16'h7FF8, 16'h0010, 12'h7FF, 12'h001, 16'd4};
    vecs[4] = '{2, 0,  0, 16'hABC0, 16'h1230, 12'hABC, 12'h123, 16'd0};

    // Reset state
    #2;
    check("reset_outputs",
          {xadc_daddr, xadc_den, xadc_dwe, m_axis_tdata, m_axis_tvalid,
           m_axis_tdest, m_axis_tlast, busy}, 0);
    check("reset_counters", {overrun_count, timeout_count}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven sweeps
    for (int i = 0; i < 4; i++) run_sweep(vecs[i], $sformatf("vec%0d", i));

    // EOS coincident with the final handshake
    beats.delete();
    hit = 1'b0;
    done = 1'b0;
    m_axis_tready = 1'b1;
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (m_axis_tvalid && m_axis_tdest == 1'b1) begin
        xadc_eos = 1'b1;
        tick();
        xadc_eos = 1'b0;
        hit = 1'b1;
      end else begin
        tick();
      end
    end
    check("coinc_reached", hit, 1);
    check("coinc_den", xadc_den, 1);
    check("coinc_daddr", xadc_daddr, 7'h13);
    check("coinc_overrun", overrun_count, 16'd4);
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (!busy && beats.size() >= 4) done = 1'b1;
    end
    check("coinc_done", done, 1);
    check("coinc_nbeats", beats.size(), 4);
    check("coinc_beat2", beats[2], {12'h7FF, 1'b0, 1'b0});
    check("coinc_beat3", beats[3], {12'h001, 1'b1, 1'b1});
    $display("coincident eos: beats=%0d overrun=%0d", beats.size(), overrun_count);

    // Reset in PRESENT with tvalid high
    hit = 1'b0;
    m_axis_tready = 1'b0;
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      if (m_axis_tvalid) hit = 1'b1;
    end
    check("rst_tvalid_seen", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {xadc_daddr, xadc_den, m_axis_tdata, m_axis_tvalid,
           m_axis_tdest, m_axis_tlast, busy}, 0);
    check("rst_async_counter", overrun_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_sweep(vecs[4], "post_reset");

`ifdef XADC_SCANNER_TIMEOUT_EN
    // Timeout on channel 1
    withhold_1b = 1'b1;
    beats.delete();
    done = 1'b0;
    m_axis_tready = 1'b1;
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check("tmo_idle", done, 1);
    check("tmo_nbeats", beats.size(), 1);
    check("tmo_beat0", beats[0], {12'hABC, 1'b0, 1'b0});
    check("tmo_count", timeout_count, 16'd1);
    $display("timeout sweep: beats=%0d timeout_count=%0d", beats.size(), timeout_count);
    withhold_1b = 1'b0;
    run_sweep(vecs[4], "after_tmo");
`else
    check("tmo_disabled", timeout_count, 16'd0);
`endif

    // Overrun saturation: hold beat 0 and keep EOS high for 70000 cycles
    hit = 1'b0;
    done = 1'b0;
    m_axis_tready = 1'b0;
    xadc_eos = 1'b1;
    tick();
    xadc_eos = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      if (m_axis_tvalid) hit = 1'b1;
    end
    check("sat_tvalid_seen", hit, 1);
    xadc_eos = 1'b1;
    for (int c = 0; c < 70000; c++) tick();
    xadc_eos = 1'b0;
    check("sat_overrun", overrun_count, 16'hFFFF);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check("sat_done", done, 1);
    check("sat_overrun_hold", overrun_count, 16'hFFFF);
    $display("saturation: overrun=%0h", overrun_count);

    check("den_protocol", den_viol, 0);
    check("dwe_zero", xadc_dwe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
